fb_scanout_reader: RTL and testbench
====================================

# fb_scanout_reader

Read-side PLB master for the double-buffered framebuffer. On each frame start it walks the selected colour plane in raster order (line 0..LAST_LINE, col 0..LAST_COL). It issues one single-beat IPIF master read per pixel and pushes the returned colour, tagged with end-of-line and end-of-frame flags, into the pixel FIFO feeding the display pipeline. It uses the same address map as the fragment writer: `{FB_BASE_ADDR, buffer, plane, line, col, 2'b0}`, with plane 0 = colour.

## Interface
Parameters:
- FB_BASE_ADDR, 9'b1001_0000_0, address bits [0:8] of both framebuffers
- LINE_LEN, 9, line counter width
- COL_LEN, 10, column counter width
- LAST_COL, 'd639, final column index
- LAST_LINE, 'd479, final line index
- PIX_FIFO_LEN, 34, pixel FIFO word width `{eof, eol, color[0:31]}`
- C_MST_AWIDTH, 32, IPIF address width
- C_MST_DWIDTH, 32, IPIF data width

Ports (one clock; reset is asynchronous and active-low):
- PLB_clk  in  1  sole clock
- Bus2IP_Resetn  in  1  asynchronous active-low reset
- enable  in  1  scanout permitted
- frame_start  in  1  one-cycle pulse requesting a frame scan
- buffer_sel  in  1  front buffer to scan; sampled at frame start
- pix_fifo_data  out  PIX_FIFO_LEN  `{eof, eol, color}`
- pix_fifo_wr_en  out  1  one-cycle push strobe
- pix_fifo_full  in  1  pixel FIFO full
- busy  out  1  frame scan in progress
- frame_done  out  1  one-cycle pulse after the last pixel is pushed
- err  out  1  sticky bus-error flag
- IP2Bus_MstRd_Req  out  1  read request
- IP2Bus_MstWr_Req  out  1  tied 0
- IP2Bus_Mst_Addr  out  C_MST_AWIDTH  read address
- IP2Bus_Mst_BE  out  C_MST_DWIDTH/8  tied all ones
- IP2Bus_Mst_Lock, IP2Bus_Mst_Reset  out  1  tied 0
- IP2Bus_MstWr_d  out  C_MST_DWIDTH  tied 0
- Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Cmd_Timeout  in  1  IPIF status
- Bus2IP_MstRd_d  in  C_MST_DWIDTH  read data
- Bus2IP_MstRd_src_rdy_n  in  1  read data valid, active-low

## Operation
- Reset values: all outputs 0 except IP2Bus_Mst_BE = all ones. State = IDLE; line, col, buf_q, rd_data = 0.
- IDLE: if frame_start && enable, latch buf_q <= buffer_sel, clear line and col, and go to WAIT. frame_start in any other state is ignored. busy = (state != IDLE).
- WAIT:
  - If !enable, go to IDLE (abort; no frame_done).
  - Else if !pix_fifo_full, load IP2Bus_Mst_Addr <= {FB_BASE_ADDR, buf_q, 1'b0, line, col, 2'b0}, set rd_req, and go to REQ.
- REQ: hold rd_req and address until Bus2IP_Mst_CmdAck, then clear rd_req. If Cmplt arrives in the same cycle as CmdAck, go to PUSH; otherwise go to DATA.
- DATA: wait for Bus2IP_Mst_Cmplt, then go to PUSH.
- Data capture: in REQ or DATA, any cycle with src_rdy_n == 0 loads rd_data <= Bus2IP_MstRd_d. This includes the Cmplt cycle.
- Error handling: if Cmplt coincides with Error or Cmd_Timeout, set err (sticky until reset) and force rd_data to 0. The pixel is still pushed, so raster alignment is preserved.
- PUSH: for exactly one cycle:
  - pix_fifo_wr_en = 1
  - pix_fifo_data = {eof, eol, rd_data}, with eol = (col == LAST_COL) and eof = eol && (line == LAST_LINE)
  - advance: if !eol, col++ and go to WAIT; if eol && !eof, col <= 0, line++, and go to WAIT; if eof, pulse frame_done and go to IDLE.
- One read is outstanding at most. FIFO space is checked in WAIT, and this block is the FIFO's only writer, so the slot is guaranteed at PUSH.
- Counters never wrap past LAST_COL/LAST_LINE. Address bit positions: buffer at 22, plane at 21, line at 12..20, col at 2..11.
- Reset asserted mid-transaction: all state clears immediately (asynchronous) and rd_req drops. After release the block stays in IDLE until the next frame_start.

## Timing
- All outputs are registered. rd_req rises the cycle after WAIT sees !full and falls the cycle after CmdAck.
- Address is stable from rd_req rise through Cmplt.
- Minimum per-pixel cost is 4 cycles (WAIT, REQ, DATA, PUSH) when CmdAck is in the first REQ cycle and Cmplt is in the first DATA cycle. It is 3 cycles when CmdAck and Cmplt coincide.
- pix_fifo_wr_en and frame_done are single-cycle pulses. frame_done is coincident with the eof push.
- pix_fifo_full is sampled only in WAIT.

## Test plan
- Reset values: hold Bus2IP_Resetn = 0 with random inputs -> all outputs 0, BE = 4'hF, busy = 0; no rd_req after release without frame_start.
- Full-raster addressing: LAST_COL = 3, LAST_LINE = 1, buffer_sel = 1, slave acks after 2 cycles and returns data = address.
  - Expect 8 reads, first 0x9040_0000 and last 0x9040_100C.
  - Expect 8 pushes with eol on col 3 and eof only on the 8th push (color 0x9040_100C).
  - Expect frame_done coincident with the 8th push.
- Backpressure: pix_fifo_full = 1 for 10 cycles after the 2nd push -> no rd_req during those cycles; 3rd read issues the cycle after full drops; no pixel is lost.
- Bus error: Error with Cmplt on pixel (0,1) -> pushed color 0 and err = 1 stays set; remaining pixels are read normally.
- Coincident CmdAck + Cmplt + src_rdy_n = 0 with data 0xDEAD_BEEF -> push of 0xDEAD_BEEF 1 cycle later; 3-cycle pixel.
- Control edges:
  - frame_start mid-frame -> ignored, buffer unchanged.
  - enable = 0 mid-frame -> current read completes and is pushed, then the block returns to IDLE with no frame_done.
  - Reset while rd_req = 1 -> rd_req is 0 within the same cycle.

Source files
------------

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout: walks one colour plane in raster order, one IPIF read
// per pixel, pushing {eof, eol, color} into the display pixel FIFO.
module fb_scanout_reader #(
  parameter logic [8:0] FB_BASE_ADDR = 9'b1001_0000_0,
  parameter int LINE_LEN = 9,
  parameter int COL_LEN = 10,
  parameter logic [COL_LEN-1:0] LAST_COL = 'd639,
  parameter logic [LINE_LEN-1:0] LAST_LINE = 'd479,
  parameter int PIX_FIFO_LEN = 34,
  parameter int C_MST_AWIDTH = 32,
  parameter int C_MST_DWIDTH = 32
) (
  input  logic PLB_clk,
  input  logic Bus2IP_Resetn,
  input  logic enable,
  input  logic frame_start,
  input  logic buffer_sel,
  output logic [PIX_FIFO_LEN-1:0] pix_fifo_data,
  output logic pix_fifo_wr_en,
  input  logic pix_fifo_full,
  output logic busy,
  output logic frame_done,
  output logic err,
  output logic IP2Bus_MstRd_Req,
  output logic IP2Bus_MstWr_Req,
  output logic [C_MST_AWIDTH-1:0] IP2Bus_Mst_Addr,
  output logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE,
  output logic IP2Bus_Mst_Lock,
  output logic IP2Bus_Mst_Reset,
  output logic [C_MST_DWIDTH-1:0] IP2Bus_MstWr_d,
  input  logic Bus2IP_Mst_CmdAck,
  input  logic Bus2IP_Mst_Cmplt,
  input  logic Bus2IP_Mst_Error,
  input  logic Bus2IP_Mst_Cmd_Timeout,
  input  logic [C_MST_DWIDTH-1:0] Bus2IP_MstRd_d,
  input  logic Bus2IP_MstRd_src_rdy_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_DATA,
    S_PUSH
  } state_t;

  state_t state_q, state_d;

  logic [LINE_LEN-1:0] line_q;
  logic [COL_LEN-1:0] col_q;
  logic buf_q;
  logic [C_MST_DWIDTH-1:0] rd_data;
  logic [C_MST_DWIDTH-1:0] data_nxt;
  logic eol, eof;
  logic start, issue, done, bad, cap, in_bus;

  assign IP2Bus_MstWr_Req = 1'b0;
  assign IP2Bus_Mst_BE = '1;
  assign IP2Bus_Mst_Lock = 1'b0;
  assign IP2Bus_Mst_Reset = 1'b0;
  assign IP2Bus_MstWr_d = '0;

  assign eol = (col_q == LAST_COL);
  assign eof = eol && (line_q == LAST_LINE);
  assign start = (state_q == S_IDLE) && frame_start && enable;
  assign issue = (state_q == S_WAIT) && enable && !pix_fifo_full;
  assign in_bus = (state_q == S_REQ) || (state_q == S_DATA);
  assign cap = in_bus && !Bus2IP_MstRd_src_rdy_n;
  assign done = ((state_q == S_REQ) && Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt)
             || ((state_q == S_DATA) && Bus2IP_Mst_Cmplt);
  assign bad = Bus2IP_Mst_Error || Bus2IP_Mst_Cmd_Timeout;

  // A failed read still yields a (black) pixel so the raster stays aligned.
  always_comb begin
    data_nxt = rd_data;
    if (cap)
      data_nxt = Bus2IP_MstRd_d;
    if (done && bad)
      data_nxt = '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_WAIT;
      S_WAIT: begin
        if (!enable)
          state_d = S_IDLE;
        else if (!pix_fifo_full)
          state_d = S_REQ;
      end
      S_REQ: begin
        if (Bus2IP_Mst_CmdAck)
          state_d = Bus2IP_Mst_Cmplt ? S_PUSH : S_DATA;
      end
      S_DATA: if (Bus2IP_Mst_Cmplt) state_d = S_PUSH;
      S_PUSH: state_d = eof ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PLB_clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge PLB_clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      line_q <= '0;
      col_q <= '0;
      buf_q <= 1'b0;
      rd_data <= '0;
      IP2Bus_MstRd_Req <= 1'b0;
      IP2Bus_Mst_Addr <= '0;
      pix_fifo_data <= '0;
      pix_fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      if (start) begin
        buf_q <= buffer_sel;
        line_q <= '0;
        col_q <= '0;
      end
      if (issue) begin
        IP2Bus_Mst_Addr <= {FB_BASE_ADDR, buf_q, 1'b0,
                            line_q, col_q, 2'b00};
        IP2Bus_MstRd_Req <= 1'b1;
      end else if ((state_q == S_REQ) && Bus2IP_Mst_CmdAck) begin
        IP2Bus_MstRd_Req <= 1'b0;
      end
      rd_data <= data_nxt;
      if (done && bad)
        err <= 1'b1;
      pix_fifo_wr_en <= done;
      frame_done <= done && eof;
      if (done)
        pix_fifo_data <= {eof, eol, data_nxt};
      busy <= (state_d != S_IDLE);
      if (state_q == S_PUSH) begin
        if (!eol) begin
          col_q <= col_q + 1'b1;
        end else if (!eof) begin
          col_q <= '0;
          line_q <= line_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Randomized scoreboard bench for fb_scanout_reader on a 4x2 raster with a
// behavioural IPIF slave and a raster-order reference model.
module tb_fb_scanout_reader;

  localparam int LC = 3;
  localparam int LL = 1;
  localparam int NPIX = (LC + 1) * (LL + 1);

  logic PLB_clk = 1'b0;
  logic Bus2IP_Resetn = 1'b0;
  logic enable = 1'b0;
  logic frame_start = 1'b0;
  logic buffer_sel = 1'b0;
  logic [33:0] pix_fifo_data;
  logic pix_fifo_wr_en;
  logic pix_fifo_full = 1'b0;
  logic busy;
  logic frame_done;
  logic err;
  logic IP2Bus_MstRd_Req;
  logic IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [3:0] IP2Bus_Mst_BE;
  logic IP2Bus_Mst_Lock;
  logic IP2Bus_Mst_Reset;
  logic [31:0] IP2Bus_MstWr_d;
  logic Bus2IP_Mst_CmdAck = 1'b0;
  logic Bus2IP_Mst_Cmplt = 1'b0;
  logic Bus2IP_Mst_Error = 1'b0;
  logic Bus2IP_Mst_Cmd_Timeout = 1'b0;
  logic [31:0] Bus2IP_MstRd_d = '0;
  logic Bus2IP_MstRd_src_rdy_n = 1'b1;

  fb_scanout_reader #(
    .LAST_COL(10'(LC)),
    .LAST_LINE(9'(LL))
  ) dut (
    .PLB_clk(PLB_clk),
    .Bus2IP_Resetn(Bus2IP_Resetn),
    .enable(enable),
    .frame_start(frame_start),
    .buffer_sel(buffer_sel),
    .pix_fifo_data(pix_fifo_data),
    .pix_fifo_wr_en(pix_fifo_wr_en),
    .pix_fifo_full(pix_fifo_full),
    .busy(busy),
    .frame_done(frame_done),
    .err(err),
    .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req),
    .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr),
    .IP2Bus_Mst_BE(IP2Bus_Mst_BE),
    .IP2Bus_Mst_Lock(IP2Bus_Mst_Lock),
    .IP2Bus_Mst_Reset(IP2Bus_Mst_Reset),
    .IP2Bus_MstWr_d(IP2Bus_MstWr_d),
    .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck),
    .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error(Bus2IP_Mst_Error),
    .Bus2IP_Mst_Cmd_Timeout(Bus2IP_Mst_Cmd_Timeout),
    .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
    .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n)
  );

  always #5 PLB_clk = ~PLB_clk;

  int unsigned cyc = 0;
  always @(posedge PLB_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [31:0] exp_addr[$];
  logic [33:0] exp_pix[$];
  int unsigned push_t[$];
  int n_reads = 0;
  int n_push = 0;

  int ack_lo = 0, ack_hi = 0, cmp_lo = 0, cmp_hi = 0, coin_pct = 0;
  bit err_on = 0;
  logic [31:0] err_adr = '0;
  bit ovr_on = 0;
  logic [31:0] ovr_dat = '0;

  function automatic logic [31:0] pix_addr(bit b, int ln, int cl);
    return 32'h9000_0000 + (32'(b) << 22) + (32'(ln) << 12) + (32'(cl) << 2);
  endfunction

  function automatic logic [31:0] pix_color(logic [31:0] a);
    if (err_on && a == err_adr) return 32'h0;
    if (ovr_on) return ovr_dat;
    return a;
  endfunction

  task automatic expect_frame(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      int ln, cl;
      logic [31:0] a;
      bit eol, eof;
      ln = i / (LC + 1);
      cl = i % (LC + 1);
      a = pix_addr(b, ln, cl);
      eol = (cl == LC);
      eof = eol && (ln == LL);
      exp_addr.push_back(a);
      exp_pix.push_back({eof, eol, pix_color(a)});
    end
  endtask

  // IPIF slave: acks after a random delay, completes with data = address
  initial begin
    int ph, cnt;
    logic [31:0] a;
    bit coin;
    ph = 0; cnt = 0; a = '0; coin = 0;
    forever begin
      @(negedge PLB_clk);
      if (!Bus2IP_Resetn) begin
        ph = 0;
        Bus2IP_Mst_CmdAck = 1'($urandom);
        Bus2IP_Mst_Cmplt = 1'($urandom);
        Bus2IP_Mst_Error = 1'($urandom);
        Bus2IP_Mst_Cmd_Timeout = 1'($urandom);
        Bus2IP_MstRd_src_rdy_n = 1'($urandom);
        Bus2IP_MstRd_d = $urandom;
      end else begin
        bit fin;
        fin = 0;
        Bus2IP_Mst_CmdAck = 0;
        Bus2IP_Mst_Cmplt = 0;
        Bus2IP_Mst_Error = 0;
        Bus2IP_Mst_Cmd_Timeout = 0;
        Bus2IP_MstRd_src_rdy_n = 1;
        Bus2IP_MstRd_d = $urandom;
        if (ph == 0 && IP2Bus_MstRd_Req) begin
          a = IP2Bus_Mst_Addr;
          cnt = $urandom_range(ack_hi, ack_lo);
          coin = ($urandom_range(99, 0) < coin_pct);
          ph = 1;
        end
        if (ph == 1) begin
          if (cnt == 0) begin
            Bus2IP_Mst_CmdAck = 1;
            if (coin) fin = 1;
            else begin
              cnt = $urandom_range(cmp_hi, cmp_lo);
              ph = 2;
            end
          end else begin
            cnt--;
            Bus2IP_MstRd_src_rdy_n = 1'($urandom);
          end
        end else if (ph == 2) begin
          if (cnt == 0) fin = 1;
          else begin
            cnt--;
            Bus2IP_MstRd_src_rdy_n = 1'($urandom);
          end
        end
        if (fin) begin
          ph = 0;
          Bus2IP_Mst_Cmplt = 1;
          Bus2IP_MstRd_src_rdy_n = 0;
          Bus2IP_MstRd_d = ovr_on ? ovr_dat : a;
          if (err_on && a == err_adr) begin
            if ($urandom_range(1, 0) == 1) Bus2IP_Mst_Error = 1;
            else Bus2IP_Mst_Cmd_Timeout = 1;
          end
          check("addr_stable", IP2Bus_Mst_Addr, a);
        end
      end
    end
  end

  // Monitor: scoreboard for read addresses and FIFO pushes
  initial begin
    bit prev;
    prev = 0;
    forever begin
      @(negedge PLB_clk);
      if (IP2Bus_MstRd_Req && !prev) begin
        n_reads++;
        check("read_expected", 64'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0)
          check("read_addr", IP2Bus_Mst_Addr, exp_addr.pop_front());
      end
      prev = IP2Bus_MstRd_Req;
      if (pix_fifo_wr_en) begin
        n_push++;
        push_t.push_back(cyc);
        check("push_expected", 64'(exp_pix.size() != 0), 1);
        if (exp_pix.size() != 0) begin
          logic [33:0] e;
          e = exp_pix.pop_front();
          check("pix_data", pix_fifo_data, e);
          check("frame_done_eof", frame_done, e[33]);
        end
      end else if (frame_done) begin
        check("frame_done_alone", frame_done, 0);
      end
    end
  end

  task automatic start_frame(input bit b);
    @(negedge PLB_clk);
    buffer_sel = b;
    enable = 1;
    frame_start = 1;
    @(negedge PLB_clk);
    frame_start = 0;
    buffer_sel = 1'($urandom);
    check("busy_in_frame", busy, 1);
  endtask

  task automatic drain_check(input string nm);
    repeat (3) @(negedge PLB_clk);
    check({nm, "_addr_q_empty"}, exp_addr.size(), 0);
    check({nm, "_pix_q_empty"}, exp_pix.size(), 0);
    check({nm, "_idle"}, busy, 0);
  endtask

  // mode 0 plain, 1 random full, 2 backpressure, 3 mid-frame frame_start
  task automatic run_frame(input bit b, input int mode);
    int pushes;
    bit done;
    expect_frame(b, NPIX);
    start_frame(b);
    pushes = 0;
    done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge PLB_clk);
      if (mode == 1) pix_fifo_full = ($urandom_range(3, 0) == 0);
      if (frame_done) done = 1;
      if (pix_fifo_wr_en) begin
        pushes++;
        if (mode == 2 && pushes == 2) begin
          bit seen;
          seen = 0;
          pix_fifo_full = 1;
          repeat (10) begin
            @(negedge PLB_clk);
            seen |= IP2Bus_MstRd_Req;
          end
          check("bp_no_req", seen, 0);
          pix_fifo_full = 0;
          @(negedge PLB_clk);
          check("bp_req_resume", IP2Bus_MstRd_Req, 1);
        end
        if (mode == 3 && pushes == 3) begin
          frame_start = 1;
          buffer_sel = ~b;
          @(negedge PLB_clk);
          frame_start = 0;
        end
      end
    end
    pix_fifo_full = 0;
    check("frame_completed", done, 1);
    drain_check("frame");
  endtask

  initial begin
    int r0, p0;
    bit fd, fired;
    // reset with random inputs
    repeat (5) begin
      @(negedge PLB_clk);
      enable = 1'($urandom);
      frame_start = 1'($urandom);
      buffer_sel = 1'($urandom);
      pix_fifo_full = 1'($urandom);
    end
    check("rst_rd_req", IP2Bus_MstRd_Req, 0);
    check("rst_wr_req", IP2Bus_MstWr_Req, 0);
    check("rst_addr", IP2Bus_Mst_Addr, 0);
    check("rst_be", IP2Bus_Mst_BE, 4'hF);
    check("rst_lock", IP2Bus_Mst_Lock, 0);
    check("rst_mreset", IP2Bus_Mst_Reset, 0);
    check("rst_wr_d", IP2Bus_MstWr_d, 0);
    check("rst_pix_data", pix_fifo_data, 0);
    check("rst_wr_en", pix_fifo_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    @(negedge PLB_clk);
    frame_start = 0;
    enable = 1;
    pix_fifo_full = 0;
    Bus2IP_Resetn = 1;
    repeat (10) @(negedge PLB_clk);
    check("no_req_after_rst", n_reads, 0);
    check("idle_after_rst", busy, 0);

    // full raster, buffer 1, ack after 2 cycles
    ack_lo = 2; ack_hi = 2; cmp_lo = 0; cmp_hi = 0; coin_pct = 0;
    r0 = n_reads;
    p0 = n_push;
    run_frame(1, 0);
    check("raster_reads", n_reads - r0, NPIX);
    check("raster_pushes", n_push - p0, NPIX);

    // backpressure after the 2nd push
    ack_lo = 0; ack_hi = 3; cmp_lo = 0; cmp_hi = 3; coin_pct = 30;
    run_frame(0, 2);

    // bus error on pixel (0,1)
    check("err_clear", err, 0);
    err_on = 1;
    err_adr = pix_addr(1, 0, 1);
    run_frame(1, 0);
    err_on = 0;
    check("err_set", err, 1);

    // coincident ack+cmplt: 3-cycle pixels
    ack_lo = 0; ack_hi = 0; cmp_lo = 0; cmp_hi = 0; coin_pct = 100;
    ovr_on = 1;
    ovr_dat = 32'hDEAD_BEEF;
    push_t.delete();
    run_frame(0, 0);
    ovr_on = 0;
    check("coin_push_count", push_t.size(), NPIX);
    for (int i = 1; i < push_t.size(); i++)
      check("spacing3", push_t[i] - push_t[i-1], 3);

    // ack then cmplt one cycle later: 4-cycle pixels
    coin_pct = 0;
    push_t.delete();
    run_frame(1, 0);
    check("min_push_count", push_t.size(), NPIX);
    for (int i = 1; i < push_t.size(); i++)
      check("spacing4", push_t[i] - push_t[i-1], 4);

    // random frames with random FIFO full
    for (int f = 0; f < 3; f++) begin
      ack_lo = 0; ack_hi = 3; cmp_lo = 0; cmp_hi = 3;
      coin_pct = $urandom_range(60, 0);
      run_frame(1'($urandom), 1);
    end
    check("err_sticky", err, 1);

    // frame_start mid-frame is ignored
    run_frame(0, 3);

    // enable dropped while the 3rd read is in flight
    expect_frame(1, 3);
    start_frame(1);
    p0 = n_push;
    fired = 0;
    for (int c = 0; c < 2000 && !fired; c++) begin
      @(negedge PLB_clk);
      if (n_push - p0 == 2 && IP2Bus_MstRd_Req) begin
        enable = 0;
        fired = 1;
      end
    end
    check("abort_fired", fired, 1);
    fd = 0;
    repeat (30) begin
      @(negedge PLB_clk);
      fd |= frame_done;
    end
    check("abort_no_done", fd, 0);
    check("abort_pushes", n_push - p0, 3);
    drain_check("abort");
    enable = 1;

    // reset while a read is outstanding
    expect_frame(0, NPIX);
    start_frame(0);
    fired = 0;
    for (int c = 0; c < 200 && !fired; c++) begin
      @(negedge PLB_clk);
      if (IP2Bus_MstRd_Req) fired = 1;
    end
    check("rst_mid_req_seen", fired, 1);
    #2 Bus2IP_Resetn = 0;
    #1;
    check("rst_mid_rd_req", IP2Bus_MstRd_Req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_err", err, 0);
    exp_addr.delete();
    exp_pix.delete();
    repeat (3) @(negedge PLB_clk);
    Bus2IP_Resetn = 1;
    r0 = n_reads;
    repeat (15) @(negedge PLB_clk);
    check("rst_mid_no_req", n_reads - r0, 0);
    check("rst_mid_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
